// File: rtl/seq_ctrl.sv
// AGC instruction sequencer: issue/stall control, branch flush, RUPT entry.
// Define SEQ_RUPT_EN to build interrupt arbitration and the RUPT0/RUPT1 bubble.
module seq_ctrl #(
    parameter int NRUPT  = 10,
    parameter int DV_MCT = 6,
    parameter int MP_MCT = 3
) (
    input  logic             clock,
    input  logic             rst_l,
    input  logic             instr_valid,
    input  logic [2:0]       op_class,
    input  logic             prefix,
    input  logic             inhint,
    input  logic             relint,
    input  logic             resume,
    input  logic [NRUPT-1:0] rupt_req,
    output logic             accept,
    output logic             stall,
    output logic             flush,
    output logic             rupt_take,
    output logic [11:0]      rupt_vec,
    output logic             in_rupt,
    output logic             halted
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        RUN,
        MULTI,
        RUPT0,
        RUPT1,
        HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          prefix_last;
    logic          prefix_last_nxt;
    logic          eligible;
    logic          rupt_go;

    always_ff @(posedge clock) begin
        if (!rst_l) begin
            state       <= RUN;
            cnt         <= '0;
            prefix_last <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            prefix_last <= prefix_last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        rupt_go   = 1'b0;
        halted    = 1'b0;
        unique case (state)
            RUN: begin
                if (eligible) begin
                    stall     = 1'b1;
                    flush     = 1'b1;
                    rupt_go   = 1'b1;
                    state_nxt = RUPT0;
                end else if (instr_valid) begin
                    accept = 1'b1;
                    unique case (op_class)
                        3'd0: state_nxt = RUN;
                        3'd1: begin
                            cnt_nxt   = '0;
                            state_nxt = MULTI;
                        end
                        3'd2: begin
                            cnt_nxt   = CW'(MP_MCT - 2);
                            state_nxt = MULTI;
                        end
                        3'd3: begin
                            cnt_nxt   = CW'(DV_MCT - 2);
                            state_nxt = MULTI;
                        end
                        3'd4: flush = 1'b1;
                        default: state_nxt = HALT;
                    endcase
                end
            end
            MULTI: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RUPT0: begin
                stall     = 1'b1;
                state_nxt = RUPT1;
            end
            RUPT1: begin
                stall     = 1'b1;
                state_nxt = RUN;
            end
            HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    // A prefix stays "open" until its target is accepted.
    assign prefix_last_nxt = accept ? prefix : prefix_last;

`ifdef SEQ_RUPT_EN
    logic [NRUPT-1:0] pending;
    logic [NRUPT-1:0] clr;
    logic             inhibit;
    logic             in_svc;
    logic [3:0]       idx;

    always_comb begin
        idx = '0;
        for (int i = NRUPT - 1; i >= 0; i--) begin
            if (pending[i]) idx = 4'(i);
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < NRUPT; i++) begin
            clr[i] = rupt_go && (idx == 4'(i));
        end
    end

    assign eligible = (|pending) && !inhibit && !in_svc && !prefix_last;

    // A request seen on the take cycle survives the clear.
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            pending <= '0;
            inhibit <= 1'b0;
            in_svc  <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | rupt_req;
            if (accept && relint) begin
                inhibit <= 1'b0;
            end else if (accept && inhint) begin
                inhibit <= 1'b1;
            end
            if (rupt_go) begin
                in_svc <= 1'b1;
            end else if (accept && resume) begin
                in_svc <= 1'b0;
            end
        end
    end

    assign rupt_take = rupt_go;
    assign rupt_vec  = rupt_go ? (12'o4000 + 12'({idx, 2'b00})) : 12'd0;
    assign in_rupt   = in_svc;
`else
    logic unused_rupt;

    assign eligible    = 1'b0;
    assign rupt_take   = 1'b0;
    assign rupt_vec    = 12'd0;
    assign in_rupt     = 1'b0;
    assign unused_rupt = ^{rupt_req, inhint, relint, resume, rupt_go};
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: cycle model plus directed literal checks.
module tb_seq_ctrl;

    localparam int NRUPT  = 10;
    localparam int DV_MCT = 6;
    localparam int MP_MCT = 3;

`ifdef SEQ_RUPT_EN
    localparam bit RUPT_EN = 1'b1;
`else
    localparam bit RUPT_EN = 1'b0;
`endif

    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] DOUBLE = 3'd1;
    localparam logic [2:0] MP     = 3'd2;
    localparam logic [2:0] DV     = 3'd3;
    localparam logic [2:0] BRANCH = 3'd4;
    localparam logic [2:0] HALTOP = 3'd5;
    localparam logic [2:0] ILLOP  = 3'd7;

    logic             clock;
    logic             rst_l;
    logic             instr_valid;
    logic [2:0]       op_class;
    logic             prefix;
    logic             inhint;
    logic             relint;
    logic             resume;
    logic [NRUPT-1:0] rupt_req;
    logic             accept;
    logic             stall;
    logic             flush;
    logic             rupt_take;
    logic [11:0]      rupt_vec;
    logic             in_rupt;
    logic             halted;

    int checks = 0;
    int errors = 0;

    seq_ctrl #(
        .NRUPT(NRUPT),
        .DV_MCT(DV_MCT),
        .MP_MCT(MP_MCT)
    ) dut (
        .clock(clock),
        .rst_l(rst_l),
        .instr_valid(instr_valid),
        .op_class(op_class),
        .prefix(prefix),
        .inhint(inhint),
        .relint(relint),
        .resume(resume),
        .rupt_req(rupt_req),
        .accept(accept),
        .stall(stall),
        .flush(flush),
        .rupt_take(rupt_take),
        .rupt_vec(rupt_vec),
        .in_rupt(in_rupt),
        .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: remaining stall cycles instead of sequencer states.
    bit               model_on = 1'b0;
    bit               m_halt;
    int               m_busy;
    logic [NRUPT-1:0] m_pend;
    bit               m_inh;
    bit               m_inr;
    bit               m_pfx;

    always @(negedge clock) begin
        bit          e_acc, e_stall, e_flush, e_take;
        logic [11:0] e_vec;
        int          lo;
        if (!rst_l) begin
            model_on = 1'b1;
            m_halt   = 1'b0;
            m_busy   = 0;
            m_pend   = '0;
            m_inh    = 1'b0;
            m_inr    = 1'b0;
            m_pfx    = 1'b0;
        end else if (model_on) begin
            e_acc   = 1'b0;
            e_stall = 1'b0;
            e_flush = 1'b0;
            e_take  = 1'b0;
            e_vec   = 12'd0;
            check("m_halted", {31'd0, halted}, {31'd0, m_halt});
            check("m_in_rupt", {31'd0, in_rupt}, {31'd0, m_inr});
            if (m_halt) begin
                e_stall = 1'b1;
            end else if (m_busy > 0) begin
                e_stall = 1'b1;
                m_busy  = m_busy - 1;
            end else if (RUPT_EN && m_pend != 0 && !m_inh && !m_inr &&
                         !m_pfx) begin
                lo = -1;
                for (int i = NRUPT - 1; i >= 0; i--) begin
                    if (m_pend[i]) lo = i;
                end
                e_stall   = 1'b1;
                e_flush   = 1'b1;
                e_take    = 1'b1;
                e_vec     = 12'o4000 + 12'(4 * lo);
                m_pend[lo] = 1'b0;
                m_inr     = 1'b1;
                m_busy    = 2;
            end else if (instr_valid) begin
                e_acc = 1'b1;
                m_pfx = prefix;
                case (op_class)
                    SINGLE: ;
                    DOUBLE: m_busy = 1;
                    MP:     m_busy = MP_MCT - 1;
                    DV:     m_busy = DV_MCT - 1;
                    BRANCH: e_flush = 1'b1;
                    default: m_halt = 1'b1;
                endcase
                if (RUPT_EN) begin
                    if (relint) m_inh = 1'b0;
                    else if (inhint) m_inh = 1'b1;
                    if (resume) m_inr = 1'b0;
                end
            end
            if (RUPT_EN) m_pend = m_pend | rupt_req;
            check("m_accept", {31'd0, accept}, {31'd0, e_acc});
            check("m_stall", {31'd0, stall}, {31'd0, e_stall});
            check("m_flush", {31'd0, flush}, {31'd0, e_flush});
            check("m_take", {31'd0, rupt_take}, {31'd0, e_take});
            check("m_vec", {20'd0, rupt_vec}, {20'd0, e_vec});
        end
    end

    task automatic cyc(input logic v, input logic [2:0] op, input logic pfx,
                       input logic ih, input logic rl, input logic rs,
                       input logic [NRUPT-1:0] req);
        @(posedge clock);
        #1;
        rst_l       = 1'b1;
        instr_valid = v;
        op_class    = op;
        prefix      = pfx;
        inhint      = ih;
        relint      = rl;
        resume      = rs;
        rupt_req    = req;
        @(negedge clock);
    endtask

    task automatic ins(input logic [2:0] op);
        cyc(1'b1, op, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        rst_l       = 1'b0;
        instr_valid = 1'b0;
        op_class    = SINGLE;
        prefix      = 1'b0;
        inhint      = 1'b0;
        relint      = 1'b0;
        resume      = 1'b0;
        rupt_req    = '0;
        @(negedge clock);
    endtask

    task automatic lit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    initial begin
        rst_l       = 1'b0;
        instr_valid = 1'b0;
        op_class    = SINGLE;
        prefix      = 1'b0;
        inhint      = 1'b0;
        relint      = 1'b0;
        resume      = 1'b0;
        rupt_req    = '0;
        do_reset();
        do_reset();

        idle();
        lit("rst_accept", accept, 1'b0);
        lit("rst_stall", stall, 1'b0);
        lit("rst_halted", halted, 1'b0);
        lit("rst_in_rupt", in_rupt, 1'b0);
        check("rst_vec", {20'd0, rupt_vec}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            ins(SINGLE);
            lit("single_acc", accept, 1'b1);
            lit("single_stall", stall, 1'b0);
        end

        ins(DV);
        lit("dv_acc", accept, 1'b1);
        for (int i = 0; i < DV_MCT - 1; i++) begin
            ins(SINGLE);
            lit("dv_stall", stall, 1'b1);
            lit("dv_noacc", accept, 1'b0);
        end
        ins(SINGLE);
        lit("dv_next_acc", accept, 1'b1);

        ins(MP);
        for (int i = 0; i < MP_MCT - 1; i++) begin
            ins(SINGLE);
            lit("mp_stall", stall, 1'b1);
        end
        ins(SINGLE);
        lit("mp_next_acc", accept, 1'b1);

        ins(DOUBLE);
        ins(SINGLE);
        lit("dbl_stall", stall, 1'b1);
        ins(SINGLE);
        lit("dbl_next_acc", accept, 1'b1);

        ins(BRANCH);
        lit("br_flush", flush, 1'b1);
        lit("br_acc", accept, 1'b1);
        ins(SINGLE);
        lit("br_after_flush", flush, 1'b0);

`ifdef SEQ_RUPT_EN
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000010100);
        lit("r1_acc", accept, 1'b1);
        ins(SINGLE);
        lit("r1_take", rupt_take, 1'b1);
        lit("r1_noacc", accept, 1'b0);
        check("r1_vec", {20'd0, rupt_vec}, {20'd0, 12'o4010});
        ins(SINGLE);
        lit("r1_bub0", stall, 1'b1);
        lit("r1_inr", in_rupt, 1'b1);
        ins(SINGLE);
        lit("r1_bub1", stall, 1'b1);
        ins(SINGLE);
        lit("r1_svc_acc", accept, 1'b1);
        lit("r1_blocked", rupt_take, 1'b0);
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        lit("r1_resume_acc", accept, 1'b1);
        ins(SINGLE);
        lit("r2_take", rupt_take, 1'b1);
        check("r2_vec", {20'd0, rupt_vec}, {20'd0, 12'o4020});
        idle();
        idle();
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);

        cyc(1'b1, SINGLE, 1'b1, 1'b0, 1'b0, 1'b0, 10'b0000000010);
        lit("pfx_acc", accept, 1'b1);
        ins(SINGLE);
        lit("pfx_notake", rupt_take, 1'b0);
        lit("pfx_tgt_acc", accept, 1'b1);
        ins(SINGLE);
        lit("pfx_take", rupt_take, 1'b1);
        check("pfx_vec", {20'd0, rupt_vec}, {20'd0, 12'o4004});
        idle();
        idle();
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);

        cyc(1'b1, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000000001);
        ins(SINGLE);
        lit("inh_notake", rupt_take, 1'b0);
        lit("inh_acc", accept, 1'b1);
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        lit("rel_notake", rupt_take, 1'b0);
        ins(SINGLE);
        lit("rel_take", rupt_take, 1'b1);
        check("rel_vec", {20'd0, rupt_vec}, {20'd0, 12'o4000});
        idle();
        idle();
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);

        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000001000);
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000001000);
        lit("rea_take", rupt_take, 1'b1);
        check("rea_vec", {20'd0, rupt_vec}, {20'd0, 12'o4014});
        idle();
        idle();
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        ins(SINGLE);
        lit("rea_take2", rupt_take, 1'b1);
        check("rea_vec2", {20'd0, rupt_vec}, {20'd0, 12'o4014});
        idle();
        idle();
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);

        cyc(1'b1, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, SINGLE, 1'b0, 1'b1, 1'b1, 1'b0, 10'b0000000001);
        ins(SINGLE);
        lit("both_take", rupt_take, 1'b1);
        idle();
        idle();
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);

        cyc(1'b1, DV, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0001000000);
        for (int i = 0; i < DV_MCT - 1; i++) begin
            ins(SINGLE);
            lit("multi_notake", rupt_take, 1'b0);
        end
        ins(SINGLE);
        lit("multi_take", rupt_take, 1'b1);
        check("multi_vec", {20'd0, rupt_vec}, {20'd0, 12'o4030});
        idle();
        idle();
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, '0);
`endif

        ins(DV);
        cyc(1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0000100000);
        ins(SINGLE);
        lit("dvrst_stall", stall, 1'b1);
        do_reset();
        idle();
        lit("dvrst_nostall", stall, 1'b0);
        lit("dvrst_notake", rupt_take, 1'b0);
        ins(SINGLE);
        lit("dvrst_acc", accept, 1'b1);
        lit("dvrst_notake2", rupt_take, 1'b0);

        ins(ILLOP);
        lit("ill_acc", accept, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ins(SINGLE);
            lit("ill_halted", halted, 1'b1);
            lit("ill_stall", stall, 1'b1);
            lit("ill_noacc", accept, 1'b0);
        end
        do_reset();
        idle();
        lit("halt_rst", halted, 1'b0);
        ins(HALTOP);
        ins(SINGLE);
        lit("halt_op", halted, 1'b1);
        do_reset();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
